fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage: PC generator, instruction-memory request/response master, and small prefetch FIFO.
- Sits directly upstream of decode, and consumes the pipeline controller's set_pc_valid/set_pc, flush_F and stall_F.
- Delivers {pc, instr, access-fault} to ID with a valid/ready handshake.
- Discards stale in-flight responses after any redirect or flush.

Parameters:
- BOOT_ADDR, 32'h0000_0000: first fetch address after reset.
- FIFO_DEPTH, 2: prefetch entries; also the cap on (outstanding + buffered) fetches. Legal values: 2 or 4.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- set_pc_valid  in  1  redirect request from controller
- set_pc  in  32  redirect target
- flush_F  in  1  drop fetched-but-unconsumed instructions
- stall_F  in  1  hold ID output (no pop)
- instr_req  out  1  memory request
- instr_addr  out  32  request address, word aligned
- instr_gnt  in  1  request accepted
- instr_rvalid  in  1  response valid, in order
- instr_rdata  in  32  response data
- instr_err  in  1  response access fault
- id_ready  in  1  decode accepts head entry
- instr_valid_id  out  1  head entry valid
- instr_id  out  32  head instruction
- pc_if  out  32  head PC
- instr_acs_fault_id  out  1  head entry faulted

Behaviour:
Reset:
- instr_req=0, instr_addr=BOOT_ADDR, instr_valid_id=0, instr_id=0, pc_if=BOOT_ADDR, instr_acs_fault_id=0.
- FIFO empty, outstanding=0, discard=0, FSM=IDLE.

FSM states: IDLE, FETCH, HOLD.
- IDLE: single cycle after reset release, no request; then FETCH.
- FETCH:
  - instr_req=1 when outstanding + fifo_count < FIFO_DEPTH.
  - On instr_gnt: outstanding++ and fetch_addr += 4.
- HOLD: entered on redirect/flush while instr_req=1 and instr_gnt=0.
  - Request stays asserted with the old address, which must stay stable until granted.
  - On grant: the granted transaction is counted as discard, then FETCH resumes with the pending target.

Bus rules:
- instr_addr only changes in a cycle after a grant or when req=0.
- rvalid arrives at least 1 cycle after gnt, in order.
- If rvalid and gnt occur in the same cycle, both counter updates apply.

Responses:
- If discard>0: decrement discard and drop the response.
- Otherwise push {pc, rdata, err} into the FIFO. The entry PC comes from a PC queue captured at grant.

Pop:
- Head is popped when instr_valid_id & id_ready & !stall_F.
- Push and pop in the same cycle are both allowed when full.
- Output is the registered FIFO head: a response is visible to ID no earlier than the cycle after rvalid, so 2 cycles minimum from grant.

Redirect (set_pc_valid):
- FIFO cleared in the same cycle.
- All outstanding transactions are moved to discard.
- fetch_addr = {set_pc[31:2], 2'b00}.
- First new request issues the next cycle, or after HOLD completes.

Flush without redirect (flush_F & !set_pc_valid):
- Same clearing as redirect.
- Restart address = pc of the dropped head if the FIFO is non-empty; otherwise the PC of the oldest outstanding fetch; otherwise fetch_addr. This is the fence replay.

Priorities and corner cases:
- set_pc_valid has priority over flush_F.
- Redirect overrides stall_F.
- A push arriving in the same cycle as a flush is discarded.
- A redirect during HOLD replaces the pending target; the last one wins.
- Fault entries propagate normally; fetching continues sequentially after a fault.
- fetch_addr wraps modulo 2^32.
- Reset asserted mid-transaction returns everything to reset values immediately. The bus slave is reset by the same reset_n.

Decomposition:
- Shared core package gets the constant INSTR_ALIGN_MASK and a typedef fetch_entry_t {pc[31:0], instr[31:0], err}.
- One sub-module: fetch_fifo (parameterised depth, push/pop/clear, count, head out).
- The outstanding/discard counters and FSM stay in fetch_unit.

Test Plan:
- Reset release, gnt tied 1, rvalid 1 cycle later, id_ready=1: requests at 0x0, 0x4, 0x8. First instr_valid_id two cycles after first gnt with pc_if=0x0; steady one instruction per cycle.
- id_ready=0 for 10 cycles, depth 2: at most 2 grants outstanding+buffered and instr_req drops. Releasing id_ready resumes without losing or duplicating 0x8/0xC.
- set_pc_valid with set_pc=0x100 while 2 responses are in flight: both stale responses dropped; next valid is pc_if=0x100 with the data from the 0x100 request.
- Redirect while req=1 and gnt held 0 for 3 cycles: instr_addr stays stable at the old address until gnt, that response is discarded, and the next request is 0x200.
- flush_F alone with head pc=0x40 buffered: FIFO cleared, refetch starts at 0x40, and ID sees pc_if=0x40 again.
- Response with instr_err=1 at 0x80: instr_acs_fault_id=1 with pc_if=0x80; next entry pc_if=0x84 with fault 0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types: prefetch entry layout, FSM states,
// alignment mask and counter width.
package fetch_unit_pkg;

  localparam logic [31:0] INSTR_ALIGN_MASK = 32'hFFFF_FFFC;

  // Wide enough for repeated redirects piling up stale responses.
  localparam int CNT_W = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] align_pc(
    input logic [31:0] a
  );
    return a & INSTR_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: registered head, push/pop/clear, occupancy count.
// Ports: clear, push/push_data, pop, count, valid, head.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int          DEPTH  = 2,
  parameter logic [31:0] RST_PC = 32'h0,
  localparam int         PW     = $clog2(DEPTH),
  localparam int         CW     = PW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  output logic [CW-1:0] count,
  output logic          valid,
  output fetch_entry_t  head
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam fetch_entry_t RST_ENTRY = '{
    pc:    RST_PC,
    instr: 32'h0,
    err:   1'b0
  };

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign valid   = (count != '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop & valid;
  // A full FIFO still accepts a push when the head leaves.
  assign do_push = push & ((count != DEPTH_C) | do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= RST_ENTRY;
      end
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC generation, instruction bus master, prefetch FIFO.
// Ports: redirect/flush/stall in, instr_* bus, ID head + handshake.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        set_pc_valid,
  input  logic [31:0] set_pc,
  input  logic        flush_F,
  input  logic        stall_F,
  output logic        instr_req,
  output logic [31:0] instr_addr,
  input  logic        instr_gnt,
  input  logic        instr_rvalid,
  input  logic [31:0] instr_rdata,
  input  logic        instr_err,
  input  logic        id_ready,
  output logic        instr_valid_id,
  output logic [31:0] instr_id,
  output logic [31:0] pc_if,
  output logic        instr_acs_fault_id
);

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int FCW = PW + 1;

  localparam logic [CNT_W-1:0] DEPTH_C =
    CNT_W'(FIFO_DEPTH);

  fetch_state_e     state;
  fetch_state_e     state_n;
  logic [31:0]      fetch_addr;
  logic [31:0]      fetch_addr_n;
  logic [31:0]      hold_addr;
  logic [31:0]      restart_pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] outstanding_n;
  logic [CNT_W-1:0] discard;
  logic [CNT_W-1:0] discard_n;
  logic [31:0]      pcq [FIFO_DEPTH];
  logic [PW-1:0]    pcq_rd;
  logic [PW-1:0]    pcq_wr;
  logic [FCW-1:0]   fifo_cnt;
  logic             fifo_valid;
  fetch_entry_t     head;
  fetch_entry_t     push_data;
  logic             redirect;
  logic             room;
  logic             grant;
  logic             grant_kept;
  logic             grant_drop;
  logic             resp_keep;
  logic             resp_drop;
  logic             push;
  logic             pop;

  assign redirect = set_pc_valid | flush_F;

  // Cap covers both in-flight and buffered fetches.
  assign room =
    (outstanding + CNT_W'(fifo_cnt)) < DEPTH_C;

  always_comb begin
    state_n   = state;
    instr_req = 1'b0;
    unique case (state)
      IDLE: begin
        state_n = FETCH;
      end
      FETCH: begin
        instr_req = room;
        // Ungranted request must keep its address.
        if (redirect && room && !instr_gnt) begin
          state_n = HOLD;
        end
      end
      HOLD: begin
        instr_req = 1'b1;
        if (instr_gnt) begin
          state_n = FETCH;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign instr_addr =
    (state == HOLD) ? hold_addr : fetch_addr;

  assign grant      = instr_req & instr_gnt;
  assign grant_kept =
    grant & (state == FETCH) & !redirect;
  assign grant_drop = grant & !grant_kept;
  assign resp_drop  = instr_rvalid & (discard != '0);
  assign resp_keep  = instr_rvalid & (discard == '0);

  assign pcq_wr = pcq_rd + outstanding[PW-1:0];

  assign push = resp_keep & !redirect;
  assign pop  = fifo_valid & id_ready & !stall_F;

  assign push_data = '{
    pc:    pcq[pcq_rd],
    instr: instr_rdata,
    err:   instr_err
  };

  // Replay from the oldest instruction ID has not taken.
  always_comb begin
    restart_pc = fetch_addr;
    if (fifo_valid) begin
      restart_pc = head.pc;
    end else if (outstanding != '0) begin
      restart_pc = pcq[pcq_rd];
    end
  end

  always_comb begin
    fetch_addr_n = fetch_addr;
    if (set_pc_valid) begin
      fetch_addr_n = align_pc(set_pc);
    end else if (flush_F) begin
      fetch_addr_n = restart_pc;
    end else if (grant_kept) begin
      fetch_addr_n = fetch_addr + 32'd4;
    end
  end

  always_comb begin
    outstanding_n = outstanding
                  + CNT_W'(grant_kept)
                  - CNT_W'(resp_keep);
    discard_n     = discard
                  - CNT_W'(resp_drop)
                  + CNT_W'(grant_drop);
    // Everything still in flight becomes stale.
    if (redirect) begin
      discard_n     = discard_n + outstanding_n;
      outstanding_n = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      fetch_addr  <= align_pc(BOOT_ADDR);
      hold_addr   <= align_pc(BOOT_ADDR);
      outstanding <= '0;
      discard     <= '0;
      pcq_rd      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pcq[i] <= '0;
      end
    end else begin
      state       <= state_n;
      fetch_addr  <= fetch_addr_n;
      outstanding <= outstanding_n;
      discard     <= discard_n;
      if (state == FETCH && state_n == HOLD) begin
        hold_addr <= fetch_addr;
      end
      if (grant_kept) begin
        pcq[pcq_wr] <= fetch_addr;
      end
      if (redirect) begin
        pcq_rd <= '0;
      end else if (resp_keep) begin
        pcq_rd <= pcq_rd + PW'(1);
      end
    end
  end

  fetch_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .RST_PC (align_pc(BOOT_ADDR))
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (redirect),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .count     (fifo_cnt),
    .valid     (fifo_valid),
    .head      (head)
  );

  assign instr_valid_id     = fifo_valid;
  assign instr_id           = head.instr;
  assign pc_if              = head.pc;
  assign instr_acs_fault_id = head.err;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: random bus slave,
// architectural next-PC model, directed corner scenarios.
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] BOOT  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        set_pc_valid;
  logic [31:0] set_pc;
  logic        flush_F;
  logic        stall_F;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_gnt;
  logic        instr_rvalid;
  logic [31:0] instr_rdata;
  logic        instr_err;
  logic        id_ready;
  logic        instr_valid_id;
  logic [31:0] instr_id;
  logic [31:0] pc_if;
  logic        instr_acs_fault_id;

  always #5 clk = ~clk;

  fetch_unit #(
    .BOOT_ADDR  (BOOT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .set_pc_valid       (set_pc_valid),
    .set_pc             (set_pc),
    .flush_F            (flush_F),
    .stall_F            (stall_F),
    .instr_req          (instr_req),
    .instr_addr         (instr_addr),
    .instr_gnt          (instr_gnt),
    .instr_rvalid       (instr_rvalid),
    .instr_rdata        (instr_rdata),
    .instr_err          (instr_err),
    .id_ready           (id_ready),
    .instr_valid_id     (instr_valid_id),
    .instr_id           (instr_id),
    .pc_if              (pc_if),
    .instr_acs_fault_id (instr_acs_fault_id)
  );

  int          n_chk  = 0;
  int          n_fail = 0;
  int unsigned cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Memory contents and fault map.
  function automatic logic [31:0] mem_data(
    input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  function automatic logic mem_err(
    input logic [31:0] a);
    return a[7:0] == 8'h80;
  endfunction

  // Bus slave: random grant, in-order responses.
  int          lat_min = 1;
  int          lat_max = 1;
  int          gnt_pct = 100;
  int          rv_pct  = 100;
  logic        gnt_block = 1'b0;
  logic [31:0] sq_addr[$];
  int unsigned sq_due[$];
  logic [31:0] gaddr[$];
  int unsigned gcyc[$];

  initial begin
    instr_gnt    = 1'b0;
    instr_rvalid = 1'b0;
    instr_rdata  = '0;
    instr_err    = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      instr_gnt    = 1'b0;
      instr_rvalid = 1'b0;
      instr_rdata  = '0;
      instr_err    = 1'b0;
      if (!reset_n) begin
        sq_addr.delete();
        sq_due.delete();
      end else begin
        if (sq_addr.size() > 0 &&
            sq_due[0] <= cyc &&
            $urandom_range(99) < rv_pct) begin
          instr_rvalid = 1'b1;
          instr_rdata  = mem_data(sq_addr[0]);
          instr_err    = mem_err(sq_addr[0]);
          void'(sq_addr.pop_front());
          void'(sq_due.pop_front());
        end
        if (!gnt_block &&
            $urandom_range(99) < gnt_pct)
          instr_gnt = 1'b1;
        if (instr_gnt && instr_req) begin
          sq_addr.push_back(instr_addr);
          sq_due.push_back(cyc +
            $urandom_range(lat_max, lat_min));
          gaddr.push_back(instr_addr);
          gcyc.push_back(cyc);
        end
      end
    end
  end

  // Architectural model: ID must see the next program-order PC.
  logic [31:0] exp_pc = BOOT;
  logic [31:0] popped[$];
  logic        prev_pend = 1'b0;
  logic [31:0] prev_addr = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        exp_pc    = BOOT;
        prev_pend = 1'b0;
      end else begin
        if (instr_valid_id) begin
          chk("head_pc", pc_if, exp_pc);
          chk("head_instr", instr_id,
              mem_data(exp_pc));
          chk("head_fault",
              32'(instr_acs_fault_id),
              32'(mem_err(exp_pc)));
        end
        if (prev_pend) begin
          chk("req_held", 32'(instr_req), 1);
          chk("addr_stable", instr_addr, prev_addr);
        end
        if (instr_req)
          chk("addr_align", 32'(instr_addr[1:0]), 0);
        prev_pend = instr_req && !instr_gnt;
        prev_addr = instr_addr;
        if (set_pc_valid) begin
          exp_pc = set_pc & 32'hFFFF_FFFC;
        end else if (!flush_F && instr_valid_id &&
                     id_ready && !stall_F) begin
          popped.push_back(exp_pc);
          exp_pc = exp_pc + 32'd4;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got running expected done");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic redirect_to(input logic [31:0] t);
    set_pc_valid = 1'b1;
    set_pc       = t;
    step();
    set_pc_valid = 1'b0;
  endtask

  task automatic wait_head(input string name);
    int k = 0;
    while (!instr_valid_id && k < 60) begin
      step();
      k++;
    end
    chk(name, 32'(k < 60), 1);
  endtask

  task automatic chk_reset_vals();
    chk("rst_req", 32'(instr_req), 0);
    chk("rst_addr", instr_addr, BOOT);
    chk("rst_valid", 32'(instr_valid_id), 0);
    chk("rst_instr", instr_id, 0);
    chk("rst_pc", pc_if, BOOT);
    chk("rst_fault", 32'(instr_acs_fault_id), 0);
  endtask

  initial begin
    int          k;
    int          np;
    int          ng;
    int          p0;
    logic [31:0] h;
    logic [31:0] old;

    reset_n      = 1'b0;
    set_pc_valid = 1'b0;
    set_pc       = '0;
    flush_F      = 1'b0;
    stall_F      = 1'b0;
    id_ready     = 1'b1;

    // Reset values and first-fetch latency.
    step(3);
    chk_reset_vals();
    reset_n = 1'b1;
    k = 0;
    while (!instr_valid_id && k < 20) begin
      step();
      k++;
    end
    chk("first_valid_seen", 32'(instr_valid_id), 1);
    chk("first_lat", cyc - gcyc[0], 2);
    chk("first_pc", pc_if, 32'h0);
    chk("first_instr", instr_id, 32'hDEAD_0000);
    step(8);
    chk("req0", gaddr[0], 32'h0);
    chk("req1", gaddr[1], 32'h4);
    chk("req2", gaddr[2], 32'h8);
    chk("pop0", popped[0], 32'h0);
    chk("pop1", popped[1], 32'h4);
    chk("pop2", popped[2], 32'h8);
    chk("pop3", popped[3], 32'hC);

    // Backpressure: cap reached, request drops.
    id_ready = 1'b0;
    step(10);
    chk("stall_req_low", 32'(instr_req), 0);
    chk("stall_valid", 32'(instr_valid_id), 1);
    chk("stall_cap",
        32'(gaddr.size() - popped.size() <= DEPTH), 1);
    h = pc_if;
    chk("stall_head", h, popped[popped.size()-1] + 4);
    np = popped.size();
    id_ready = 1'b1;
    step(10);
    chk("resume_cnt", 32'(popped.size() >= np + 2), 1);
    if (popped.size() >= np + 2) begin
      chk("resume_pc0", popped[np], h);
      chk("resume_pc1", popped[np+1], h + 32'd4);
    end

    // Redirect with two stale responses in flight.
    lat_min = 3;
    lat_max = 3;
    step(6);
    k = 0;
    while (sq_addr.size() < 2 && k < 40) begin
      step();
      k++;
    end
    chk("inflight2", 32'(sq_addr.size() >= 2), 1);
    redirect_to(32'h100);
    wait_head("redir_wait");
    chk("redir_pc", pc_if, 32'h100);
    chk("redir_instr", instr_id, 32'hDEAD_0100);
    lat_min = 1;
    lat_max = 1;
    step(6);

    // Redirect while the request waits for a grant.
    gnt_block = 1'b1;
    k = 0;
    while (!instr_req && k < 40) begin
      step();
      k++;
    end
    chk("hold_req_seen", 32'(instr_req), 1);
    old = instr_addr;
    ng  = gaddr.size();
    redirect_to(32'h200);
    for (int i = 0; i < 3; i++) begin
      chk("hold_req", 32'(instr_req), 1);
      chk("hold_addr", instr_addr, old);
      step();
    end
    gnt_block = 1'b0;
    k = 0;
    while (gaddr.size() < ng + 2 && k < 40) begin
      step();
      k++;
    end
    chk("hold_grants", 32'(gaddr.size() >= ng + 2), 1);
    if (gaddr.size() >= ng + 2) begin
      chk("hold_g_old", gaddr[ng], old);
      chk("hold_g_new", gaddr[ng+1], 32'h200);
    end
    wait_head("hold_wait");
    chk("hold_first_pc", pc_if, 32'h200);
    step(4);

    // Flush replays the buffered head.
    id_ready = 1'b0;
    redirect_to(32'h40);
    k = 0;
    while (!instr_valid_id && k < 40) begin
      step();
      k++;
    end
    chk("fl_head_pc", pc_if, 32'h40);
    flush_F = 1'b1;
    step();
    flush_F = 1'b0;
    chk("fl_cleared", 32'(instr_valid_id), 0);
    id_ready = 1'b1;
    wait_head("fl_wait");
    chk("fl_replay_pc", pc_if, 32'h40);
    chk("fl_replay_instr", instr_id, 32'hDEAD_0040);
    step(4);

    // Access fault entry, then sequential continuation.
    redirect_to(32'h80);
    wait_head("flt_wait");
    chk("flt_pc", pc_if, 32'h80);
    chk("flt_bit", 32'(instr_acs_fault_id), 1);
    step();
    wait_head("flt_next_wait");
    chk("flt_next_pc", pc_if, 32'h84);
    chk("flt_next_bit", 32'(instr_acs_fault_id), 0);

    // Address wrap at the top of memory.
    redirect_to(32'hFFFF_FFFE);
    wait_head("wrap_wait");
    chk("wrap_pc0", pc_if, 32'hFFFF_FFFC);
    step();
    wait_head("wrap_wait2");
    chk("wrap_pc1", pc_if, 32'h0);

    // Random traffic against the model.
    gnt_pct = 60;
    rv_pct  = 70;
    lat_min = 1;
    lat_max = 4;
    p0 = popped.size();
    for (int i = 0; i < 3000; i++) begin
      id_ready     = ($urandom_range(99) < 75);
      stall_F      = ($urandom_range(99) < 10);
      flush_F      = ($urandom_range(99) < 3);
      set_pc_valid = ($urandom_range(99) < 3);
      if ($urandom_range(7) == 0)
        set_pc = 32'hFFFF_FFF0 +
                 32'($urandom_range(15));
      else
        set_pc = 32'($urandom_range(1023));
      step();
    end
    set_pc_valid = 1'b0;
    flush_F      = 1'b0;
    stall_F      = 1'b0;
    id_ready     = 1'b1;
    step(20);
    chk("rand_progress",
        32'(popped.size() - p0 > 150), 1);

    // Asynchronous reset in the middle of traffic.
    gnt_pct = 100;
    rv_pct  = 100;
    step(5);
    reset_n = 1'b0;
    #1;
    chk_reset_vals();
    step(2);
    reset_n = 1'b1;
    wait_head("rst2_wait");
    chk("rst2_pc", pc_if, BOOT);
    step(5);

    $display(
      "End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end

endmodule
